rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 8:1 32-bit select datapath.
//  Eight requesters present data beats with req/last. The block grants one requester
//  at a time for a burst and drives the 3-bit select that steers that requester's
//  data onto a single registered output stream with a valid/ready handshake.
//  It sits between the requesting units and the shared downstream consumer.
// PARAMETERS
//  DATA_W     32  width of each requester data word and of d_out
//  MAX_BURST  16  max beats per grant; forced release at this count (>=1, <=256)
// PORTS
//  clk        input   1         rising-edge clock, sole clock
//  reset      input   1         synchronous, active-high reset
//  req        input   8         req[i]=1: requester i has a beat on its data slice
//  last       input   8         last[i]=1: current beat of requester i ends its burst
//  data_in    input   8*DATA_W  requester i data = data_in[i*DATA_W +: DATA_W]
//  ack        output  8         one-hot, combinational: beat of requester i taken this cycle
//  grant      output  8         one-hot registered grant; 0 in IDLE
//  sel        output  3         registered index of the granted requester (mux select)
//  d_out      output  DATA_W    registered output data
//  out_valid  output  1         d_out holds a beat
//  out_ready  input   1         consumer accepts d_out when out_valid & out_ready
// BEHAVIOUR
//  Reset (reset=1 at clk edge):
//   - grant=0, sel=0, rr pointer=0, burst_cnt=0, out_valid=0, d_out=0, state=IDLE.
//   - Reset overrides every other event, including mid-burst; in-flight beat dropped.
//  FSM states:
//   - IDLE: if req!=0, pick the first set req[i] scanning from ptr upward, wrap 7->0.
//     Next cycle: state=BUSY, sel=i, grant=1<<i, burst_cnt=0. No ack in IDLE.
//   - BUSY: space = !out_valid | out_ready. take = req[sel] & space.
//     ack = take ? (1<<sel) : 0.
//  Output register:
//   - On take: d_out<=data_in slice sel, out_valid<=1. One-cycle latency ack->out_valid.
//   - Else if out_ready: out_valid<=0; d_out holds its value.
//   - Back-to-back beats sustain 1 beat/clk while out_ready=1.
//  Release BUSY->IDLE (grant=0 next cycle; ptr<=sel+1 mod 8):
//   - take & last[sel]
//   - take & burst_cnt==MAX_BURST-1
//   - req[sel]==0: requester withdrew mid-burst; no ack that cycle
//  Other rules:
//   - burst_cnt increments on each take, 8-bit, cleared on grant.
//   - One IDLE bubble cycle between grants. Output may still drain during IDLE.
//   - req/last of non-granted requesters are ignored. last without take is ignored.
//   - Stall (out_valid=1, out_ready=0): no take; grant and burst_cnt hold.
//   - ptr advances only on release, so every requester is served within 8 grants.
// TESTING
//  1 Reset: hold reset 2 clk with req=8'hFF -> grant=0, sel=0, out_valid=0, d_out=0, ack=0.
//  2 Single: req=8'h08, last=8'h08, data3=32'hA5A5_0003, out_ready=1 -> grant=8'h08 one clk
//    after req; ack[3] pulses 1 clk; d_out=32'hA5A5_0003, out_valid=1 next clk; then IDLE.
//  3 Round robin: req=8'hFF held, last=8'hFF -> grant order 0,1,2,...,7,0 with sel matching;
//    one IDLE cycle between each grant.
//  4 Burst cap: MAX_BURST=16, req[5]=1, last=0 -> exactly 16 acks, then grant=0;
//    next grant goes to req[6] if set, else back to 5.
//  5 Backpressure: out_ready=0 for 5 clk mid-burst -> d_out/out_valid stable,
//    ack=0, burst_cnt holds; resumes 1 beat/clk when out_ready=1.
//  6 Withdraw/reset mid-burst: drop req[2] after 3 beats -> IDLE next clk, ptr=3.
//    Assert reset while BUSY -> all outputs return to reset values next clk.

Source files
------------

// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bus for the round-robin 8:1 select arbiter.
interface rr_mux_arbiter_if #(
   parameter int unsigned DATA_W = 32
);
   logic [7:0]          req;
   logic [7:0]          last;
   logic [8*DATA_W-1:0] data_in;
   logic [7:0]          ack;
   logic [7:0]          grant;
   logic [2:0]          sel;
   logic [DATA_W-1:0]   d_out;
   logic                out_valid;
   logic                out_ready;

   // Requesters and downstream consumer side
   modport master (
      output req, last, data_in, out_ready,
      input  ack, grant, sel, d_out, out_valid
   );

   // Arbiter side
   modport slave (
      input  req, last, data_in, out_ready,
      output ack, grant, sel, d_out, out_valid
   );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin burst arbiter driving the shared 8:1 select datapath into a
// registered valid/ready output stream.
module rr_mux_arbiter #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic               clk,
   input  logic               reset,
   rr_mux_arbiter_if.slave    bus
);
   localparam int unsigned N_REQ = 8;
   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [SEL_W-1:0]    r_sel;
   logic [SEL_W-1:0]    r_ptr;
   logic [N_REQ-1:0]    r_grant;
   logic [CNT_W-1:0]    r_burst_cnt;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_d_out;

   logic                w_space;
   logic                w_take;
   logic                w_release;
   logic                w_start;
   logic                w_found;
   logic [SEL_W-1:0]    w_pick;
   logic [SEL_W-1:0]    w_idx;
   logic [N_REQ-1:0]    w_ack;
   logic [DATA_W-1:0]   w_beat;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Round-robin pick from ptr, take/release decode and next state
   always_comb begin
      w_state_nxt = r_state;
      w_space     = !r_out_valid || bus.out_ready;
      w_take      = 1'b0;
      w_release   = 1'b0;
      w_start     = 1'b0;
      w_ack       = '0;
      w_found     = 1'b0;
      w_pick      = r_ptr;
      w_idx       = r_ptr;
      for (int k = 0; k < N_REQ; k++) begin
         w_idx = r_ptr + SEL_W'(k);
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_start     = 1'b1;
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            w_take = bus.req[r_sel] && w_space;
            if (w_take) w_ack = N_REQ'(1) << r_sel;
            // withdrawal releases without a take; last/cap only count on a take
            w_release = !bus.req[r_sel] ||
                        (w_take && (bus.last[r_sel] || (r_burst_cnt == CNT_LAST)));
            if (w_release) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_beat = bus.data_in[32'(r_sel) * DATA_W +: DATA_W];

   // Grant, select, rotation pointer and burst counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sel       <= '0;
         r_grant     <= '0;
         r_ptr       <= '0;
         r_burst_cnt <= '0;
      end else if (w_start) begin
         r_sel       <= w_pick;
         r_grant     <= N_REQ'(1) << w_pick;
         r_burst_cnt <= '0;
      end else begin
         if (w_take) r_burst_cnt <= r_burst_cnt + CNT_W'(1);
         if (w_release) begin
            r_grant <= '0;
            r_ptr   <= r_sel + SEL_W'(1);
         end
      end
   end

   // Output register: load on take, drain when consumer accepts
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_d_out     <= '0;
      end else if (w_take) begin
         r_out_valid <= 1'b1;
         r_d_out     <= w_beat;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.ack       = w_ack;
   assign bus.grant     = r_grant;
   assign bus.sel       = r_sel;
   assign bus.d_out     = r_d_out;
   assign bus.out_valid = r_out_valid;
endmodule
